// File: rtl/hd44780_responder.sv
// Bus-side model of an HD44780 controller: resynchronises E/RS/DB, rebuilds bytes and executes the instruction subset.
// Optional nibble-pair timeout is compiled in with `define HD44780_RESP_TIMEOUT_EN.
module hd44780_responder #(
    parameter int DDRAM_DEPTH    = 80,
    parameter int EXEC_CYCLES    = 10,
    parameter int CLEAR_CYCLES   = 400,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic       rs,
    input  logic [3:0] db,
    output logic       busy,
    output logic       mode_4bit,
    output logic       disp_on,
    output logic [6:0] ddram_addr,
    output logic       byte_valid,
    output logic       byte_rs,
    output logic [7:0] byte_data,
    output logic       overrun,
    output logic       timeout_err,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data
);
    localparam int CNT_MAX = (CLEAR_CYCLES > EXEC_CYCLES) ? CLEAR_CYCLES : EXEC_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] EXEC_LOAD  = CW'(EXEC_CYCLES - 1);
    localparam logic [CW-1:0] HOME_LOAD  = CW'(CLEAR_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_TAIL = CW'(CLEAR_CYCLES - 1 - DDRAM_DEPTH);
    localparam logic [6:0]    LAST_ADDR  = 7'(DDRAM_DEPTH - 1);
    localparam logic [7:0]    DEPTH8     = 8'(DDRAM_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR} state_e;

    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            r = (a >= LAST_ADDR) ? 7'd0 : a + 7'd1;
        end else begin
            r = (a == 7'd0) ? LAST_ADDR : a - 7'd1;
        end
        return r;
    endfunction

    logic       e_s1_q, e_s2_q, e_prev_q, rs_s1_q, rs_s2_q;
    logic [3:0] db_s1_q, db_s2_q;
    logic       strobe_s;

    state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0] fill_q, fill_d, addr_q, addr_d;
    logic       id_q, id_d, mode_q, mode_d, disp_q, disp_d;
    logic       phase_lo_q, phase_lo_d;
    logic [3:0] hi_q, hi_d;
    logic       busy_q, busy_d, bv_q, bv_d, brs_q, brs_d;
    logic [7:0] bdata_q, bdata_d;
    logic       overrun_q, overrun_d;
    logic       exec_go_s;
    logic [CW-1:0] exec_load_s;
    logic       we_s;
    logic [6:0] waddr_s;
    logic [7:0] wdata_s;
    logic [7:0] mem_q [DDRAM_DEPTH];
    logic [7:0] rd_data_q;
`ifdef HD44780_RESP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_err_q, tmo_err_d;
`endif

    // Two-flop synchronisers for the asynchronous bus plus E edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_s1_q   <= 1'b0;
            e_s2_q   <= 1'b0;
            e_prev_q <= 1'b0;
            rs_s1_q  <= 1'b0;
            rs_s2_q  <= 1'b0;
            db_s1_q  <= 4'h0;
            db_s2_q  <= 4'h0;
        end else begin
            e_s1_q   <= e;
            e_s2_q   <= e_s1_q;
            e_prev_q <= e_s2_q;
            rs_s1_q  <= rs;
            rs_s2_q  <= rs_s1_q;
            db_s1_q  <= db;
            db_s2_q  <= db_s1_q;
        end
    end

    assign strobe_s = e_prev_q & ~e_s2_q;

    // Byte assembly, instruction decode and busy sequencing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        addr_d      = addr_q;
        id_d        = id_q;
        mode_d      = mode_q;
        disp_d      = disp_q;
        phase_lo_d  = phase_lo_q;
        hi_d        = hi_q;
        busy_d      = busy_q;
        bv_d        = 1'b0;
        brs_d       = brs_q;
        bdata_d     = bdata_q;
        overrun_d   = overrun_q;
        exec_go_s   = 1'b0;
        exec_load_s = EXEC_LOAD;
        we_s        = 1'b0;
        waddr_s     = addr_q;
        wdata_s     = bdata_q;
`ifdef HD44780_RESP_TIMEOUT_EN
        tmo_cnt_d   = '0;
        tmo_err_d   = tmo_err_q;
`endif

        if (strobe_s) begin
            if (busy_q) begin
                overrun_d = 1'b1;
            end else if (!mode_q) begin
                bv_d    = 1'b1;
                bdata_d = {db_s2_q, 4'h0};
                brs_d   = rs_s2_q;
                busy_d  = 1'b1;
            end else if (!phase_lo_q) begin
                hi_d       = db_s2_q;
                phase_lo_d = 1'b1;
            end else begin
                bv_d       = 1'b1;
                bdata_d    = {hi_q, db_s2_q};
                brs_d      = rs_s2_q;
                phase_lo_d = 1'b0;
                busy_d     = 1'b1;
            end
        end else begin
`ifdef HD44780_RESP_TIMEOUT_EN
            // An orphaned high nibble is abandoned after TIMEOUT_CYCLES idle cycles.
            if (phase_lo_q) begin
                if (tmo_cnt_q == TMO_LAST) begin
                    phase_lo_d = 1'b0;
                    tmo_err_d  = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end else begin
                tmo_cnt_d = '0;
            end
`else
            phase_lo_d = phase_lo_q;
`endif
        end

        case (state_q)
            S_IDLE: begin
                if (bv_q) begin
                    exec_go_s = 1'b1;
                    if (brs_q) begin
                        we_s   = ({1'b0, addr_q} < DEPTH8);
                        addr_d = step_addr(addr_q, id_q);
                    end else begin
                        casez (bdata_q)
                            8'b1???_????: addr_d = bdata_q[6:0];
                            8'b001?_????: begin
                                mode_d     = ~bdata_q[4];
                                phase_lo_d = 1'b0;
                            end
                            8'b0000_1???: disp_d = bdata_q[2];
                            8'b0000_01??: id_d = bdata_q[1];
                            8'b0000_001?: begin
                                addr_d      = 7'd0;
                                exec_load_s = HOME_LOAD;
                            end
                            8'b0000_0001: begin
                                exec_go_s = 1'b0;
                                state_d   = S_CLEAR;
                                fill_d    = 7'd0;
                            end
                            default: exec_load_s = EXEC_LOAD;
                        endcase
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CLEAR: begin
                we_s    = 1'b1;
                waddr_s = fill_q;
                wdata_s = 8'h20;
                if (fill_q == LAST_ADDR) begin
                    addr_d      = 7'd0;
                    id_d        = 1'b1;
                    exec_go_s   = 1'b1;
                    exec_load_s = CLEAR_TAIL;
                end else begin
                    fill_d = fill_q + 7'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // A zero load means the decode/fill cycle already used up the whole busy window.
        if (exec_go_s) begin
            if (exec_load_s == '0) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end else begin
                state_d = S_EXEC;
                cnt_d   = exec_load_s;
            end
        end else begin
            cnt_d = cnt_d;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            fill_q     <= 7'd0;
            addr_q     <= 7'd0;
            id_q       <= 1'b1;
            mode_q     <= 1'b0;
            disp_q     <= 1'b0;
            phase_lo_q <= 1'b0;
            hi_q       <= 4'h0;
            busy_q     <= 1'b0;
            bv_q       <= 1'b0;
            brs_q      <= 1'b0;
            bdata_q    <= 8'h00;
            overrun_q  <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_q     <= fill_d;
            addr_q     <= addr_d;
            id_q       <= id_d;
            mode_q     <= mode_d;
            disp_q     <= disp_d;
            phase_lo_q <= phase_lo_d;
            hi_q       <= hi_d;
            busy_q     <= busy_d;
            bv_q       <= bv_d;
            brs_q      <= brs_d;
            bdata_q    <= bdata_d;
            overrun_q  <= overrun_d;
            rd_data_q  <= ({1'b0, rd_addr} < DEPTH8) ? mem_q[rd_addr] : 8'h00;
        end
    end

    // DDRAM image; deliberately not reset so an aborted clear keeps its partial fill.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_q[waddr_s] <= wdata_s;
        end
    end

`ifdef HD44780_RESP_TIMEOUT_EN
    // Nibble-pair timeout counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end
    assign timeout_err = tmo_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign busy       = busy_q;
    assign mode_4bit  = mode_q;
    assign disp_on    = disp_q;
    assign ddram_addr = addr_q;
    assign byte_valid = bv_q;
    assign byte_rs    = brs_q;
    assign byte_data  = bdata_q;
    assign overrun    = overrun_q;
    assign rd_data    = rd_data_q;
endmodule

// File: tb/tb_hd44780_responder.sv
// Self-checking bench for hd44780_responder: table-driven init plus hand-written multi-cycle sequences.
module tb_hd44780_responder;
    localparam int EXEC_CYCLES    = 10;
    localparam int CLEAR_CYCLES   = 400;
    localparam int TIMEOUT_CYCLES = 1000;
    localparam int DEPTH          = 80;

    logic       clk = 1'b0;
    logic       rst, e, rs;
    logic [3:0] db;
    logic       busy, mode_4bit, disp_on, byte_valid, byte_rs, overrun, timeout_err;
    logic [6:0] ddram_addr, rd_addr;
    logic [7:0] byte_data, rd_data;

    hd44780_responder #(
        .DDRAM_DEPTH(DEPTH), .EXEC_CYCLES(EXEC_CYCLES),
        .CLEAR_CYCLES(CLEAR_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .e(e), .rs(rs), .db(db),
        .busy(busy), .mode_4bit(mode_4bit), .disp_on(disp_on), .ddram_addr(ddram_addr),
        .byte_valid(byte_valid), .byte_rs(byte_rs), .byte_data(byte_data),
        .overrun(overrun), .timeout_err(timeout_err), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q [$];
    logic [8:0] obs_mem [256];
    int obs_wr = 0;
    int obs_rd = 0;
    int busy_len = 0;
    int last_busy_len = 0;
    int busy_runs = 0;

    // Capture every assembled byte and the length of every busy window.
    always @(negedge clk) begin
        if (byte_valid === 1'b1) begin
            obs_mem[obs_wr % 256] <= {byte_rs, byte_data};
            obs_wr <= obs_wr + 1;
        end
        if (busy === 1'b1) begin
            busy_len <= busy_len + 1;
        end else if (busy_len != 0) begin
            last_busy_len <= busy_len;
            busy_runs     <= busy_runs + 1;
            busy_len      <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic sb_drain();
        while (obs_rd < obs_wr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got byte 0x%0h, none expected", obs_mem[obs_rd % 256]);
            end else begin
                chk("sb_byte", 32'(obs_mem[obs_rd % 256]), 32'(exp_q.pop_front()));
            end
            obs_rd++;
        end
    endtask

    task automatic strobe(input logic r, input logic [3:0] d);
        @(posedge clk); #2;
        rs = r;
        db = d;
        @(posedge clk); #2;
        e = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        e = 1'b0;
        repeat (5) @(negedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", n);
        end
        @(negedge clk); #1;
    endtask

    task automatic send_byte(input logic r, input logic [7:0] b, input int exp_len);
        int runs0;
        runs0 = busy_runs;
        exp_q.push_back({r, b});
        strobe(r, b[7:4]);
        strobe(r, b[3:0]);
        wait_idle();
        sb_drain();
        chk("busy_runs", 32'(busy_runs - runs0), 32'd1);
        chk("busy_len", 32'(last_busy_len), 32'(exp_len));
    endtask

    task automatic read_chk(input logic [6:0] a, input logic [7:0] x, input string nm);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk); #1;
        chk(nm, 32'(rd_data), 32'(x));
    endtask

    typedef struct {
        logic       rs;
        logic [3:0] nib;
        logic       has_byte;
        logic [7:0] byte_exp;
        logic       mode_exp;
        logic [6:0] addr_exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int runs0;
        int n;
        vecs[0] = '{1'b0, 4'h3, 1'b1, 8'h30, 1'b0, 7'd0};
        vecs[1] = '{1'b0, 4'h3, 1'b1, 8'h30, 1'b0, 7'd0};
        vecs[2] = '{1'b0, 4'h3, 1'b1, 8'h30, 1'b0, 7'd0};
        vecs[3] = '{1'b0, 4'h2, 1'b1, 8'h20, 1'b1, 7'd0};
        vecs[4] = '{1'b0, 4'h8, 1'b0, 8'h00, 1'b1, 7'd0};
        vecs[5] = '{1'b0, 4'h0, 1'b1, 8'h80, 1'b1, 7'd0};
        vecs[6] = '{1'b1, 4'h6, 1'b0, 8'h00, 1'b1, 7'd0};
        vecs[7] = '{1'b1, 4'h1, 1'b1, 8'h61, 1'b1, 7'd1};

        rst = 1'b1; e = 1'b0; rs = 1'b0; db = 4'h0; rd_addr = 7'd0;
        repeat (4) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mode", 32'(mode_4bit), 32'd0);
        chk("rst_disp", 32'(disp_on), 32'd0);
        chk("rst_addr", 32'(ddram_addr), 32'd0);
        chk("rst_valid", 32'(byte_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            runs0 = busy_runs;
            if (vecs[i].has_byte) exp_q.push_back({vecs[i].rs, vecs[i].byte_exp});
            strobe(vecs[i].rs, vecs[i].nib);
            wait_idle();
            sb_drain();
            chk("vec_mode", 32'(mode_4bit), 32'(vecs[i].mode_exp));
            chk("vec_addr", 32'(ddram_addr), 32'(vecs[i].addr_exp));
            if (vecs[i].has_byte) begin
                chk("vec_busy_runs", 32'(busy_runs - runs0), 32'd1);
                chk("vec_busy_len", 32'(last_busy_len), 32'(EXEC_CYCLES));
            end else begin
                chk("vec_no_busy", 32'(busy_runs - runs0), 32'd0);
            end
        end
        read_chk(7'd0, 8'h61, "rd_a");

        send_byte(1'b0, 8'h0C, EXEC_CYCLES);
        chk("disp_on", 32'(disp_on), 32'd1);

        // Clear: fill with spaces, address back to 0, busy for the full clear window.
        send_byte(1'b0, 8'h85, EXEC_CYCLES);
        send_byte(1'b1, 8'h41, EXEC_CYCLES);
        read_chk(7'd5, 8'h41, "rd_pre_clear");
        chk("addr_pre_clear", 32'(ddram_addr), 32'd6);
        send_byte(1'b0, 8'h01, CLEAR_CYCLES);
        chk("addr_clear", 32'(ddram_addr), 32'd0);
        for (int a = 0; a < DEPTH; a++) read_chk(7'(a), 8'h20, "rd_clear");

        // Wrap upward from the last cell, then downward from cell 0.
        send_byte(1'b0, 8'hCF, EXEC_CYCLES);
        send_byte(1'b1, 8'h11, EXEC_CYCLES);
        send_byte(1'b1, 8'h22, EXEC_CYCLES);
        chk("addr_wrap_up", 32'(ddram_addr), 32'd1);
        read_chk(7'd79, 8'h11, "rd_79");
        read_chk(7'd0, 8'h22, "rd_0");
        send_byte(1'b0, 8'h04, EXEC_CYCLES);
        send_byte(1'b0, 8'h80, EXEC_CYCLES);
        send_byte(1'b1, 8'h33, EXEC_CYCLES);
        chk("addr_wrap_down", 32'(ddram_addr), 32'd79);
        read_chk(7'd0, 8'h33, "rd_0_dec");
        send_byte(1'b0, 8'h06, EXEC_CYCLES);
        send_byte(1'b0, 8'h02, CLEAR_CYCLES);
        chk("addr_home", 32'(ddram_addr), 32'd0);

        // Overrun: a strobe two cycles after byte_valid lands inside the busy window.
        chk("overrun_before", 32'(overrun), 32'd0);
        exp_q.push_back({1'b0, 8'hC0});
        strobe(1'b0, 4'hC);
        @(posedge clk); #2;
        db = 4'h0;
        @(posedge clk); #2;
        e = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        e = 1'b0;
        n = 0;
        while (byte_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("overrun_bv_seen", 32'(byte_valid), 32'd1);
        repeat (2) @(posedge clk);
        #2;
        db = 4'h9;
        e = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        e = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        wait_idle();
        sb_drain();
        chk("overrun_set", 32'(overrun), 32'd1);
        chk("addr_after_overrun", 32'(ddram_addr), 32'h40);
        send_byte(1'b0, 8'h85, EXEC_CYCLES);
        chk("phase_kept", 32'(ddram_addr), 32'd5);

`ifdef HD44780_RESP_TIMEOUT_EN
        strobe(1'b0, 4'h8);
        repeat (TIMEOUT_CYCLES + 5) @(negedge clk);
        #1;
        chk("timeout_set", 32'(timeout_err), 32'd1);
        send_byte(1'b0, 8'h80, EXEC_CYCLES);
        chk("addr_after_timeout", 32'(ddram_addr), 32'd0);
`else
        strobe(1'b0, 4'h8);
        repeat (TIMEOUT_CYCLES + 5) @(negedge clk);
        #1;
        chk("timeout_zero", 32'(timeout_err), 32'd0);
        exp_q.push_back({1'b0, 8'h80});
        strobe(1'b0, 4'h0);
        wait_idle();
        sb_drain();
        chk("addr_after_wait", 32'(ddram_addr), 32'd0);
`endif
        chk("overrun_sticky", 32'(overrun), 32'd1);
        chk("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
